// File: rtl/cp0_exc_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, exception codes
// and helpers that assemble architectural register images from their fields.
package cp0_exc_pkg;

    localparam logic [31:0] PRID_VALUE = 32'h0000_0001;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD_BIT = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] packSr(input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] v;
        v = 32'd0;
        v[SR_IM_LO +: 6] = im;
        v[SR_EXL_BIT]    = exl;
        v[SR_IE_BIT]     = ie;
        return v;
    endfunction

    function automatic logic [31:0] packCause(input logic bd, input logic [5:0] ip,
                                              input logic [4:0] excCode);
        logic [31:0] v;
        v = 32'd0;
        v[CAUSE_BD_BIT]        = bd;
        v[CAUSE_IP_LO +: 6]    = ip;
        v[CAUSE_EXC_LO +: 5]   = excCode;
        return v;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Free-running Count/Compare timer; raises a sticky pending flag when Count matches Compare.
module cp0_timer
    import cp0_exc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wrCount_i,
    input  logic        wrCompare_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;
    logic        match;

    // The match term is visible combinationally so the interrupt appears in the Count==Compare cycle.
    always_comb begin
        match     = (count_q == compare_q);
        count_d   = wrCount_i ? wdata_i : count_q + 32'd1;
        compare_d = wrCompare_i ? wdata_i : compare_q;
        pending_d = wrCompare_i ? 1'b0 : (pending_q | match);
        irq_o     = pending_q | match;
        count_o   = count_q;
        compare_o = compare_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/cp0_exc.sv
// CP0 exception/interrupt unit: SR, Cause, EPC, PRId and exception capture.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_exc
    import cp0_exc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC_out,
    output logic [31:0] DOut
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  excCode_q, excCode_d;
    logic [31:0] epc_q, epc_d;

    logic [5:0]  ipEff;
    logic        intPending;
    logic        excPending;
    logic [31:0] victimPc;
    logic        timerIrq;
    logic [31:0] timerCount;
    logic [31:0] timerCompare;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .wrCount_i   (WE && !IntReq && (A2 == REG_COUNT)),
        .wrCompare_i (WE && !IntReq && (A2 == REG_COMPARE)),
        .wdata_i     (DIn),
        .count_o     (timerCount),
        .compare_o   (timerCompare),
        .irq_o       (timerIrq)
    );
`else
    assign timerIrq     = 1'b0;
    assign timerCount   = 32'd0;
    assign timerCompare = 32'd0;
`endif

    // Gating with reset keeps IntReq low the moment reset rises, even with ExcCode_M pending.
    always_comb begin
        ipEff      = {ip_q[5] | timerIrq, ip_q[4:0]};
        intPending = (|(ipEff & im_q)) && ie_q && !exl_q;
        excPending = (ExcCode_M != 5'd0) && !exl_q;
        IntReq     = !reset && (intPending || excPending);
        victimPc   = BD_M ? (PC_M - 32'd4) : PC_M;
        EPC_out    = epc_q;
    end

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        excCode_d = excCode_q;
        epc_d     = epc_q;
        ip_d      = HWInt;
        if (IntReq) begin
            exl_d     = 1'b1;
            bd_d      = BD_M;
            epc_d     = {victimPc[31:2], 2'b00};
            excCode_d = intPending ? EXC_INT : ExcCode_M;
        end else begin
            if (WE) begin
                case (A2)
                    REG_SR: begin
                        im_d  = DIn[SR_IM_LO +: 6];
                        exl_d = DIn[SR_EXL_BIT];
                        ie_d  = DIn[SR_IE_BIT];
                    end
                    REG_EPC: epc_d = DIn;
                    default: ;
                endcase
            end
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            excCode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            excCode_q <= excCode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:      DOut = packSr(im_q, exl_q, ie_q);
            REG_CAUSE:   DOut = packCause(bd_q, ipEff, excCode_q);
            REG_EPC:     DOut = epc_q;
            REG_PRID:    DOut = PRID_VALUE;
            REG_COUNT:   DOut = timerCount;
            REG_COMPARE: DOut = timerCompare;
            default:     DOut = 32'd0;
        endcase
    end

endmodule
